// File: rtl/rob_mport.sv
// rob_mport: in-order reorder buffer with NP push and NP pop lanes per cycle.
// Optional feature macro: ROB_MPORT_FLAGSCAN_EN enables the in-flight
// branch/CSR/store flag scan. When the macro is undefined, the scan is not
// built and hasBranch/hasCsr/hasSu are tied to 0.
// Requirements: DW >= 6, because flag bits 5:3 are read. 1 <= NP <= 2**AW.
module rob_mport #(
    parameter int unsigned DW = 64,
    parameter int unsigned AW = 3,
    parameter int unsigned NP = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [$clog2(NP+1)-1:0] push_cnt,
    input  logic [NP*DW-1:0]        push_data,
    input  logic [$clog2(NP+1)-1:0] pop_cnt,
    input  logic                    flush,
    output logic [NP*DW-1:0]        pop_data,
    output logic [NP-1:0]           pop_vld,
    output logic [AW:0]             occ,
    output logic [AW:0]             free,
    output logic                    empty,
    output logic                    full,
    output logic                    hasBranch,
    output logic                    hasCsr,
    output logic                    hasSu
);

    localparam int unsigned DP = 1 << AW;
    localparam int unsigned PW = AW + 1;

    logic [DW-1:0] mem [DP];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push_ok_c;
    logic          pop_ok_c;

    // Occupancy status; the wrap bit makes the modular difference unambiguous.
    always_comb begin
        occ   = wr_ptr - rd_ptr;
        free  = PW'(DP) - occ;
        empty = (occ == '0);
        full  = (occ == PW'(DP));
    end

    // Push and pop acceptance, both judged on the state before this edge.
    always_comb begin
        push_ok_c = (32'(push_cnt) <= NP) && (PW'(push_cnt) <= free);
        pop_ok_c  = (32'(pop_cnt) <= NP) && (PW'(pop_cnt) <= occ);
    end

    // Pointer and storage update; reset clears storage, but flush does not.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int k = 0; k < int'(DP); k++) begin
                mem[AW'(k)] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push_ok_c) begin
                for (int i = 0; i < int'(NP); i++) begin
                    if (i < int'(push_cnt)) begin
                        mem[wr_ptr[AW-1:0] + AW'(i)] <= push_data[DW*i +: DW];
                    end
                end
                wr_ptr <= wr_ptr + PW'(push_cnt);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + PW'(pop_cnt);
            end
        end
    end

    // Head window presented to commit with zero latency.
    always_comb begin
        pop_data = '0;
        pop_vld  = '0;
        for (int i = 0; i < int'(NP); i++) begin
            pop_data[DW*i +: DW] = mem[rd_ptr[AW-1:0] + AW'(i)];
            pop_vld[i]           = (occ > PW'(i));
        end
    end

`ifdef ROB_MPORT_FLAGSCAN_EN
    logic [DP-1:0] win_c;

    // Valid non-head slots: offset from the head is nonzero and below occupancy.
    always_comb begin
        win_c = '0;
        for (int k = 0; k < int'(DP); k++) begin
            win_c[k] = ({1'b0, AW'(k) - rd_ptr[AW-1:0]} < occ) &&
                       (AW'(k) != rd_ptr[AW-1:0]);
        end
    end

    // OR the branch, CSR and store markers over the in-flight window.
    always_comb begin
        hasBranch = 1'b0;
        hasCsr    = 1'b0;
        hasSu     = 1'b0;
        for (int k = 0; k < int'(DP); k++) begin
            if (win_c[k]) begin
                hasBranch = hasBranch | mem[k][5];
                hasCsr    = hasCsr    | mem[k][4];
                hasSu     = hasSu     | mem[k][3];
            end
        end
    end
`else
    // The flag scan is not built.
    always_comb begin
        hasBranch = 1'b0;
        hasCsr    = 1'b0;
        hasSu     = 1'b0;
    end
`endif

endmodule

// File: tb/tb_rob_mport.sv
// Testbench for rob_mport (DW=64, AW=3, NP=2), using a queue-based reference model.
module tb_rob_mport;

    logic         CLK = 1'b0;
    logic         RST;
    logic [1:0]   push_cnt;
    logic [127:0] push_data;
    logic [1:0]   pop_cnt;
    logic         flush;
    logic [127:0] pop_data;
    logic [1:0]   pop_vld;
    logic [3:0]   occ;
    logic [3:0]   free;
    logic         empty;
    logic         full;
    logic         hasBranch;
    logic         hasCsr;
    logic         hasSu;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] q[$];

    rob_mport #(.DW(64), .AW(3), .NP(2)) dut (
        .CLK(CLK), .RST(RST), .push_cnt(push_cnt), .push_data(push_data),
        .pop_cnt(pop_cnt), .flush(flush), .pop_data(pop_data), .pop_vld(pop_vld),
        .occ(occ), .free(free), .empty(empty), .full(full),
        .hasBranch(hasBranch), .hasCsr(hasCsr), .hasSu(hasSu)
    );

    always #5 CLK = ~CLK;

    // Reference model: a queue with capacity 8, holding entries in program order.
    function automatic void model_update(input logic [1:0] pc, input logic [127:0] pd,
                                         input logic [1:0] oc, input logic fl, input logic rs);
        int n;
        bit push_ok;
        bit pop_ok;
        if (rs || fl) begin
            q.delete();
            return;
        end
        n       = q.size();
        push_ok = (pc <= 2) && (int'(pc) <= 8 - n);
        pop_ok  = (oc <= 2) && (int'(oc) <= n);
        if (pop_ok) repeat (int'(oc)) void'(q.pop_front());
        if (push_ok) for (int i = 0; i < int'(pc); i++) q.push_back(pd[64*i +: 64]);
    endfunction

    function automatic logic [14:0] exp_status();
        int n = q.size();
        logic [2:0] f = 3'b000;
`ifdef ROB_MPORT_FLAGSCAN_EN
        for (int k = 1; k < n; k++) f = f | {q[k][5], q[k][4], q[k][3]};
`endif
        return {4'(n), 4'(8 - n), n == 0, n == 8, n > 1, n > 0, f};
    endfunction

    function automatic logic [14:0] obs_status();
        return {occ, free, empty, full, pop_vld, hasBranch, hasCsr, hasSu};
    endfunction

    function automatic logic [127:0] lane_mask();
        logic [127:0] m = '0;
        for (int i = 0; i < 2; i++) if (i < q.size()) m[64*i +: 64] = {64{1'b1}};
        return m;
    endfunction

    function automatic logic [127:0] exp_data();
        logic [127:0] d = '0;
        for (int i = 0; i < 2; i++) if (i < q.size()) d[64*i +: 64] = q[i];
        return d;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Drive one cycle of stimulus, advance the model at the edge, and sample 1ns later.
    task automatic cycle(input logic [1:0] pc, input logic [127:0] pd,
                         input logic [1:0] oc, input logic fl, input logic rs);
        push_cnt = pc; push_data = pd; pop_cnt = oc; flush = fl; RST = rs;
        @(posedge CLK);
        model_update(pc, pd, oc, fl, rs);
        #1;
        push_cnt = 2'd0; pop_cnt = 2'd0; flush = 1'b0; RST = 1'b0;
    endtask

    task automatic test_reset();
        cycle(2'd2, {rnd64(), rnd64()}, 2'd0, 1'b0, 1'b1);
        n_checks++;
        if (obs_status() !== exp_status())
            $display("FAIL reset_status: got %h expected %h", obs_status(), exp_status());
        else n_pass++;
        n_checks++;
        if (pop_data !== 128'd0) $display("FAIL reset_pop_data: got %h expected 0", pop_data);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [63:0] a = 64'hA5A5_0000_1111_2222;
        logic [63:0] b = 64'hB6B6_3333_4444_5555;
        cycle(2'd2, {b, a}, 2'd0, 1'b0, 1'b0);
        n_checks++;
        if (obs_status() !== exp_status())
            $display("FAIL basic_status: got %h expected %h", obs_status(), exp_status());
        else n_pass++;
        n_checks++;
        if (pop_data !== {b, a}) $display("FAIL basic_data: got %h expected %h", pop_data, {b, a});
        else n_pass++;
    endtask

    task automatic test_fill_reject();
        logic [1:0] pcs [6] = '{2'd3, 2'd2, 2'd2, 2'd1, 2'd2, 2'd1};
        for (int s = 0; s < 6; s++) begin
            cycle(pcs[s], {rnd64(), rnd64()}, 2'd0, 1'b0, 1'b0);
            n_checks++;
            if (obs_status() !== exp_status())
                $display("FAIL fill_status step %0d: got %h expected %h", s, obs_status(), exp_status());
            else n_pass++;
            n_checks++;
            if ((pop_data & lane_mask()) !== exp_data())
                $display("FAIL fill_data step %0d: got %h expected %h", s, pop_data & lane_mask(), exp_data());
            else n_pass++;
        end
    endtask

    task automatic test_full_pushpop();
        for (int s = 0; s < 6; s++) begin
            if (s < 2) cycle(2'd2, {rnd64(), rnd64()}, 2'd2, 1'b0, 1'b0);
            else       cycle(2'd0, 128'd0, 2'd2, 1'b0, 1'b0);
            n_checks++;
            if (obs_status() !== exp_status())
                $display("FAIL pushpop_status step %0d: got %h expected %h", s, obs_status(), exp_status());
            else n_pass++;
            n_checks++;
            if ((pop_data & lane_mask()) !== exp_data())
                $display("FAIL pushpop_data step %0d: got %h expected %h", s, pop_data & lane_mask(), exp_data());
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [1:0] cnt [4] = '{2'd2, 2'd2, 2'd2, 2'd1};
        cycle(2'd0, 128'd0, 2'd0, 1'b1, 1'b0);
        for (int s = 0; s < 4; s++) cycle(cnt[s], {rnd64(), rnd64()}, 2'd0, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++) cycle(2'd0, 128'd0, cnt[s], 1'b0, 1'b0);
        for (int s = 0; s < 10; s++) begin
            cycle(2'd2, {rnd64(), rnd64()}, 2'd0, 1'b0, 1'b0);
            n_checks++;
            if ((pop_data & lane_mask()) !== exp_data() || obs_status() !== exp_status())
                $display("FAIL wrap_push step %0d: got %h/%h expected %h/%h", s,
                         pop_data & lane_mask(), obs_status(), exp_data(), exp_status());
            else n_pass++;
            cycle(2'd0, 128'd0, 2'd2, 1'b0, 1'b0);
            n_checks++;
            if (obs_status() !== exp_status() || empty !== 1'b1)
                $display("FAIL wrap_pop step %0d: got %h expected %h", s, obs_status(), exp_status());
            else n_pass++;
        end
    endtask

    task automatic test_flags();
        cycle(2'd0, 128'd0, 2'd0, 1'b1, 1'b0);
        cycle(2'd2, {64'h10, 64'h20}, 2'd0, 1'b0, 1'b0);
        cycle(2'd1, {64'h0, 64'h08}, 2'd0, 1'b0, 1'b0);
        n_checks++;
        if (obs_status() !== exp_status())
            $display("FAIL flags_three: got %h expected %h", obs_status(), exp_status());
        else n_pass++;
        cycle(2'd0, 128'd0, 2'd1, 1'b0, 1'b0);
        n_checks++;
        if (obs_status() !== exp_status())
            $display("FAIL flags_pop1: got %h expected %h", obs_status(), exp_status());
        else n_pass++;
    endtask

    task automatic test_flush();
        cycle(2'd0, 128'd0, 2'd0, 1'b1, 1'b0);
        cycle(2'd2, {64'h38, 64'h38}, 2'd0, 1'b0, 1'b0);
        cycle(2'd2, {64'h38, 64'h38}, 2'd0, 1'b0, 1'b0);
        cycle(2'd1, {64'h0, 64'h38}, 2'd0, 1'b0, 1'b0);
        n_checks++;
        if (obs_status() !== exp_status())
            $display("FAIL flush_pre: got %h expected %h", obs_status(), exp_status());
        else n_pass++;
        cycle(2'd2, {64'h38, 64'h38}, 2'd1, 1'b1, 1'b0);
        n_checks++;
        if (obs_status() !== exp_status())
            $display("FAIL flush_post: got %h expected %h", obs_status(), exp_status());
        else n_pass++;
    endtask

    task automatic test_reset_push();
        cycle(2'd2, {rnd64(), rnd64()}, 2'd0, 1'b0, 1'b0);
        cycle(2'd2, {rnd64(), rnd64()}, 2'd1, 1'b0, 1'b1);
        n_checks++;
        if (obs_status() !== exp_status())
            $display("FAIL reset_push_status: got %h expected %h", obs_status(), exp_status());
        else n_pass++;
        n_checks++;
        if (pop_data !== 128'd0) $display("FAIL reset_push_data: got %h expected 0", pop_data);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int s = 0; s < 400; s++) begin
            logic [1:0] pc = 2'($urandom_range(0, 3));
            logic [1:0] oc = 2'($urandom_range(0, 2));
            logic fl = ($urandom_range(0, 31) == 0);
            cycle(pc, {rnd64(), rnd64()}, oc, fl, 1'b0);
            n_checks++;
            if (obs_status() !== exp_status())
                $display("FAIL random_status cycle %0d: got %h expected %h", s, obs_status(), exp_status());
            else n_pass++;
            n_checks++;
            if ((pop_data & lane_mask()) !== exp_data())
                $display("FAIL random_data cycle %0d: got %h expected %h", s, pop_data & lane_mask(), exp_data());
            else n_pass++;
        end
    endtask

    initial begin
        RST = 1'b0; push_cnt = 2'd0; push_data = '0; pop_cnt = 2'd0; flush = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_fill_reject();
        test_full_pushpop();
        test_wrap();
        test_flags();
        test_flush();
        test_random();
        test_reset_push();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
